// File: rtl/lpc_enc_pkg.sv
// Shared definitions for the LPC encoder front end.
//   DATA_W_DEF / FRAME_LEN_DEF : default sample width and frame length
//   LAST_BIT / USER_BIT        : FIFO entry flag offsets above the data field,
//                                entry layout is {user, last, data}
//   fsm_state_t                : frame slicer FSM states
package lpc_enc_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAME_LEN_DEF = 4;

    localparam int LAST_BIT = 0;
    localparam int USER_BIT = 1;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/axis_frame_slicer_if.sv
// Sample-side bus of the frame slicer: AXI-Stream input beats plus the framed
// sample output toward the encoder core.
//   slave  : view of the slicer (accepts T* beats, drives the framed output)
//   master : view of the source/sink environment
interface axis_frame_slicer_if
    import lpc_enc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic               TVALID;
    logic               TREADY;
    logic [DATA_W-1:0]  TDATA;
    logic               TLAST;
    logic               TUSER;
    logic               READY;
    logic               VALID;
    logic [DATA_W-1:0]  SAMPLE;
    logic               LAST;
    logic               SAMPLE_LAST;
    logic               USER_OUT;
    logic [LEVEL_W-1:0] LEVEL;

    modport slave (
        input  TVALID, TDATA, TLAST, TUSER, READY,
        output TREADY, VALID, SAMPLE, LAST, SAMPLE_LAST, USER_OUT, LEVEL
    );

    modport master (
        output TVALID, TDATA, TLAST, TUSER, READY,
        input  TREADY, VALID, SAMPLE, LAST, SAMPLE_LAST, USER_OUT, LEVEL
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count and a read port that
// shows the head entry combinationally (first-word fall-through).
//   ACLK, ARESET_N : clock, async active-low reset
//   push, wdata    : write request and entry (ignored when full)
//   pop, rdata     : read request (ignored when empty) and head entry
//   full, empty    : occupancy flags
//   level          : number of stored entries
module axis_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESET_N,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/axis_frame_slicer.sv
// Slices an AXI-Stream sample stream into FRAME_LEN-sample analysis frames.
//   ACLK, ARESET_N : clock, async active-low reset
//   bus (slave)    : T* input beats with TREADY; READY/VALID/SAMPLE/LAST
//                    output beats, SAMPLE_LAST (beat carried TLAST),
//                    USER_OUT (resync pulse), LEVEL (FIFO occupancy)
//
// state | meaning
// PASS  | pop FIFO entries: data beats are emitted, markers restart the frame
// PAD   | emit zero samples until the current frame is complete
module axis_frame_slicer
    import lpc_enc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter bit PAD_SHORT  = 1'b1
) (
    input  logic               ACLK,
    input  logic               ARESET_N,
    axis_frame_slicer_if.slave bus
);
    localparam int EW = DATA_W + 2;
    localparam int FW = $clog2(FRAME_LEN);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(FRAME_LEN - 1);

    logic              rst_done;
    fsm_state_t        state, state_n;
    logic [FW-1:0]     fcnt, fcnt_n;
    logic [EW-1:0]     fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic              push, pop, load, load_ok, out_hs;
    logic [DATA_W-1:0] ld_sample, head_data;
    logic              ld_last, ld_slast, head_last, head_user;
    logic              out_valid, out_last, out_slast, user_q, user_n;
    logic [DATA_W-1:0] out_sample;

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) rst_done <= 1'b0;
        else           rst_done <= 1'b1;
    end

    // !fifo_full is LEVEL < FIFO_DEPTH taken from the registered count.
    assign bus.TREADY = rst_done && !fifo_full;
    assign push       = bus.TVALID && bus.TREADY;

    // Marker beats carry no sample: data and TLAST are stored as zero.
    always_comb begin
        fifo_wdata = '0;
        if (bus.TUSER) begin
            fifo_wdata[DATA_W+USER_BIT] = 1'b1;
        end else begin
            fifo_wdata[DATA_W-1:0]      = bus.TDATA;
            fifo_wdata[DATA_W+LAST_BIT] = bus.TLAST;
        end
    end

    axis_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .ACLK     (ACLK),
        .ARESET_N (ARESET_N),
        .push     (push),
        .wdata    (fifo_wdata),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign head_data = fifo_rdata[DATA_W-1:0];
    assign head_last = fifo_rdata[DATA_W+LAST_BIT];
    assign head_user = fifo_rdata[DATA_W+USER_BIT];

    assign out_hs  = out_valid && bus.READY;
    assign load_ok = !out_valid || bus.READY;

    // fcnt is the frame position of the next beat to enter the output
    // register, so LAST can be decided at load time.
    always_comb begin
        state_n   = state;
        fcnt_n    = fcnt;
        pop       = 1'b0;
        load      = 1'b0;
        ld_sample = '0;
        ld_last   = 1'b0;
        ld_slast  = 1'b0;
        user_n    = 1'b0;
        case (state)
            PASS: begin
                if (!fifo_empty && load_ok) begin
                    pop = 1'b1;
                    if (head_user) begin
                        user_n = 1'b1;
                        fcnt_n = '0;
                    end else begin
                        load      = 1'b1;
                        ld_sample = head_data;
                        ld_slast  = head_last;
                        if (fcnt == FCNT_MAX) begin
                            ld_last = 1'b1;
                            fcnt_n  = '0;
                        end else if (head_last) begin
                            if (PAD_SHORT) begin
                                fcnt_n  = fcnt + 1'b1;
                                state_n = PAD;
                            end else begin
                                ld_last = 1'b1;
                                fcnt_n  = '0;
                            end
                        end else begin
                            fcnt_n = fcnt + 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (load_ok) begin
                    load = 1'b1;
                    if (fcnt == FCNT_MAX) begin
                        ld_last = 1'b1;
                        fcnt_n  = '0;
                        state_n = PASS;
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state  <= PASS;
            fcnt   <= '0;
            user_q <= 1'b0;
        end else begin
            state  <= state_n;
            fcnt   <= fcnt_n;
            user_q <= user_n;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_last   <= 1'b0;
            out_slast  <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_sample <= ld_sample;
            out_last   <= ld_last;
            out_slast  <= ld_slast;
        end else if (out_hs) begin
            out_valid  <= 1'b0;
        end
    end

    assign bus.VALID       = out_valid;
    assign bus.SAMPLE      = out_sample;
    assign bus.LAST        = out_last;
    assign bus.SAMPLE_LAST = out_slast;
    assign bus.USER_OUT    = user_q;
    assign bus.LEVEL       = fifo_level;

endmodule

// File: tb/tb_axis_frame_slicer.sv
module tb_axis_frame_slicer;
    localparam int DW = 16;
    localparam int FL = 4;
    localparam int FD = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          sl;
    } obeat_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    bit   rnd_ready = 1'b0;

    obeat_t exp_a[$], exp_b[$], got_a[$], got_b[$];
    int fpos[2];
    int users_exp[2];
    int users_got[2];
    int rd[2];

    axis_frame_slicer_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) ifa ();
    axis_frame_slicer_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) ifb ();

    axis_frame_slicer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .PAD_SHORT(1'b1)) dut_a (
        .ACLK(aclk), .ARESET_N(aresetn), .bus(ifa));
    axis_frame_slicer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .PAD_SHORT(1'b0)) dut_b (
        .ACLK(aclk), .ARESET_N(aresetn), .bus(ifb));

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic obeat_t ob(input logic [DW-1:0] d, input logic l, input logic sl);
        obeat_t b;
        b.d = d; b.l = l; b.sl = sl;
        return b;
    endfunction

    function automatic logic [31:0] outs(input int s);
        if (s == 0)
            return 32'({ifa.TREADY, ifa.VALID, ifa.LAST, ifa.SAMPLE_LAST, ifa.USER_OUT, ifa.LEVEL, ifa.SAMPLE});
        return 32'({ifb.TREADY, ifb.VALID, ifb.LAST, ifb.SAMPLE_LAST, ifb.USER_OUT, ifb.LEVEL, ifb.SAMPLE});
    endfunction

    function automatic void push_exp(input int s, input obeat_t b);
        if (s == 0) exp_a.push_back(b);
        else        exp_b.push_back(b);
    endfunction

    // Reference: dut_a pads short frames, dut_b emits them short.
    function automatic void model_push(input int s, input logic [DW-1:0] d, input bit l, input bit u);
        if (u) begin
            fpos[s] = 0;
            users_exp[s]++;
        end else if (fpos[s] == FL - 1) begin
            push_exp(s, ob(d, 1'b1, l));
            fpos[s] = 0;
        end else if (l) begin
            if (s == 0) begin
                push_exp(s, ob(d, 1'b0, 1'b1));
                for (int k = fpos[s] + 1; k < FL; k++) push_exp(s, ob('0, k == FL - 1, 1'b0));
            end else begin
                push_exp(s, ob(d, 1'b1, 1'b1));
            end
            fpos[s] = 0;
        end else begin
            push_exp(s, ob(d, 1'b0, 1'b0));
            fpos[s]++;
        end
    endfunction

    task automatic drive(input int s, input bit v, input logic [DW-1:0] d, input bit l, input bit u);
        if (s == 0) begin ifa.TVALID = v; ifa.TDATA = d; ifa.TLAST = l; ifa.TUSER = u; end
        else        begin ifb.TVALID = v; ifb.TDATA = d; ifb.TLAST = l; ifb.TUSER = u; end
    endtask

    // One clock cycle: record handshakes/pulses before the edge, check that
    // a stalled output held across it, then optionally re-randomise READY.
    task automatic tick();
        bit     hv_a, hv_b;
        obeat_t pa, pb;
        pa   = ob(ifa.SAMPLE, ifa.LAST, ifa.SAMPLE_LAST);
        pb   = ob(ifb.SAMPLE, ifb.LAST, ifb.SAMPLE_LAST);
        hv_a = ifa.VALID && !ifa.READY;
        hv_b = ifb.VALID && !ifb.READY;
        if (ifa.VALID && ifa.READY) got_a.push_back(pa);
        if (ifb.VALID && ifb.READY) got_b.push_back(pb);
        if (ifa.USER_OUT) users_got[0]++;
        if (ifb.USER_OUT) users_got[1]++;
        @(posedge aclk);
        #1;
        if (hv_a && aresetn) check("hold_a", 32'({ifa.VALID, ifa.SAMPLE, ifa.LAST, ifa.SAMPLE_LAST}), 32'({1'b1, pa}));
        if (hv_b && aresetn) check("hold_b", 32'({ifb.VALID, ifb.SAMPLE, ifb.LAST, ifb.SAMPLE_LAST}), 32'({1'b1, pb}));
        if (rnd_ready) begin
            ifa.READY = ($urandom_range(0, 3) != 0);
            ifb.READY = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input int s, input logic [DW-1:0] d, input bit l, input bit u);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        drive(s, 1'b1, d, l, u);
        while (!acc && n < 300) begin
            acc = (s == 0) ? ifa.TREADY : ifb.TREADY;
            tick();
            n++;
        end
        drive(s, 1'b0, '0, 1'b0, 1'b0);
        check("accept", 32'(acc), 32'd1);
        if (acc) model_push(s, d, l, u);
    endtask

    function automatic bit drained(input int s);
        if (s == 0) return got_a.size() >= exp_a.size() && ifa.LEVEL == 0 && !ifa.VALID;
        return got_b.size() >= exp_b.size() && ifb.LEVEL == 0 && !ifb.VALID;
    endfunction

    task automatic cmp(input int s, input string tag, input obeat_t g[$], input obeat_t e[$]);
        check({tag, ":count"}, 32'(g.size()), 32'(e.size()));
        for (int i = rd[s]; i < e.size() && i < g.size(); i++)
            check($sformatf("%s[%0d]", tag, i - rd[s]), 32'(g[i]), 32'(e[i]));
        check({tag, ":user_pulses"}, 32'(users_got[s]), 32'(users_exp[s]));
        rd[s] = e.size();
    endtask

    task automatic drain_and_compare(input int s, input string tag);
        int n;
        n = 0;
        while (n < 600 && !drained(s)) begin tick(); n++; end
        check({tag, ":drain"}, 32'(n < 600), 32'd1);
        repeat (3) tick();
        if (s == 0) cmp(0, tag, got_a, exp_a);
        else        cmp(1, tag, got_b, exp_b);
    endtask

    initial begin
        int r;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        ifa.READY = 1'b1;
        ifb.READY = 1'b1;

        // Reset values and rst_done gating of TREADY.
        #1 aresetn = 1'b0;
        #2;
        check("reset_a", outs(0), 32'd0);
        check("reset_b", outs(1), 32'd0);
        repeat (3) tick();
        check("reset_hold_a", outs(0), 32'd0);
        aresetn = 1'b1;
        check("tready_before_rst_done", 32'(ifa.TREADY), 32'd0);
        tick();
        check("tready_after_rst_done_a", 32'(ifa.TREADY), 32'd1);
        check("tready_after_rst_done_b", 32'(ifb.TREADY), 32'd1);

        // Streaming with READY high, first-beat latency.
        send(0, 16'h0001, 1'b0, 1'b0);
        check("latency_not_yet", 32'(ifa.VALID), 32'd0);
        send(0, 16'h0002, 1'b0, 1'b0);
        check("latency_first", 32'({ifa.VALID, ifa.SAMPLE}), 32'({1'b1, 16'h0001}));
        for (int i = 3; i <= 8; i++) send(0, 16'(i), 1'b0, 1'b0);
        drain_and_compare(0, "stream");
        if (got_a.size() >= 8) begin
            check("stream_last_4", 32'(got_a[3]), 32'(ob(16'h0004, 1'b1, 1'b0)));
            check("stream_last_8", 32'(got_a[7]), 32'(ob(16'h0008, 1'b1, 1'b0)));
        end

        // Backpressure: 9 accepts (1 held in output, 8 buffered), then stall.
        ifa.READY = 1'b0;
        for (int i = 0; i < 9; i++) send(0, 16'h0010 + 16'(i), 1'b0, 1'b0);
        check("bp_level", 32'(ifa.LEVEL), 32'd8);
        check("bp_tready", 32'(ifa.TREADY), 32'd0);
        check("bp_head", 32'({ifa.VALID, ifa.SAMPLE}), 32'({1'b1, 16'h0010}));
        drive(0, 1'b1, 16'h0019, 1'b0, 1'b0);
        repeat (4) tick();
        check("bp_level_hold", 32'(ifa.LEVEL), 32'd8);
        check("bp_head_hold", 32'({ifa.VALID, ifa.SAMPLE}), 32'({1'b1, 16'h0010}));
        ifa.READY = 1'b1;
        send(0, 16'h0019, 1'b0, 1'b0);
        drain_and_compare(0, "backpressure");

        // Marker to realign, then a short frame with padding.
        send(0, 16'hBEEF, 1'b0, 1'b1);
        send(0, 16'h000A, 1'b0, 1'b0);
        send(0, 16'h000B, 1'b1, 1'b0);
        drain_and_compare(0, "short_pad");
        if (got_a.size() >= 4) begin
            check("short_pad_b",    32'(got_a[got_a.size()-3]), 32'(ob(16'h000B, 1'b0, 1'b1)));
            check("short_pad_fill", 32'(got_a[got_a.size()-2]), 32'(ob(16'h0000, 1'b0, 1'b0)));
            check("short_pad_end",  32'(got_a[got_a.size()-1]), 32'(ob(16'h0000, 1'b1, 1'b0)));
        end

        // Short frame without padding, next frame restarts at position 0.
        send(1, 16'h000A, 1'b0, 1'b0);
        send(1, 16'h000B, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) send(1, 16'(i), 1'b0, 1'b0);
        drain_and_compare(1, "short_nopad");
        if (got_b.size() >= 6) begin
            check("short_nopad_b", 32'(got_b[1]), 32'(ob(16'h000B, 1'b1, 1'b1)));
            check("short_nopad_next_last", 32'(got_b[5]), 32'(ob(16'h0004, 1'b1, 1'b0)));
        end

        // Resync marker mid-frame, then two back-to-back markers.
        send(0, 16'h0001, 1'b0, 1'b0);
        send(0, 16'h0002, 1'b0, 1'b0);
        send(0, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 3; i <= 6; i++) send(0, 16'(i), 1'b0, 1'b0);
        drain_and_compare(0, "resync");
        send(0, 16'h0007, 1'b0, 1'b0);
        send(0, 16'hFFFF, 1'b1, 1'b1);
        send(0, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 8; i <= 11; i++) send(0, 16'(i), 1'b0, 1'b0);
        drain_and_compare(0, "double_marker");

        // Reset with data in flight.
        ifa.READY = 1'b0;
        send(0, 16'h0021, 1'b0, 1'b0);
        send(0, 16'h0022, 1'b0, 1'b0);
        check("midreset_before", 32'({ifa.VALID, ifa.LEVEL}), 32'({1'b1, 4'd1}));
        aresetn = 1'b0;
        #1;
        check("midreset_outs", outs(0), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        while (exp_a.size() > got_a.size()) void'(exp_a.pop_back());
        while (exp_b.size() > got_b.size()) void'(exp_b.pop_back());
        rd[0] = exp_a.size();
        rd[1] = exp_b.size();
        fpos[0] = 0;
        fpos[1] = 0;
        ifa.READY = 1'b1;
        for (int i = 1; i <= 4; i++) send(0, 16'h0030 + 16'(i), 1'b0, 1'b0);
        drain_and_compare(0, "after_reset");
        if (got_a.size() >= 4) begin
            check("after_reset_3", 32'(got_a[got_a.size()-2]), 32'(ob(16'h0033, 1'b0, 1'b0)));
            check("after_reset_4", 32'(got_a[got_a.size()-1]), 32'(ob(16'h0034, 1'b1, 1'b0)));
        end

        // Random traffic with random READY on both variants.
        rnd_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 150; i++) begin
                r = $urandom;
                if (r[3:0] == 4'd0) tick();
                send(s, r[31:16], r[6:4] == 3'd0, r[10:7] < 4'd2);
            end
            drain_and_compare(s, (s == 0) ? "rand_pad" : "rand_nopad");
        end
        rnd_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_slicer.md
Name: axis_frame_slicer

Overview:
Parametrised AXI-Stream slave front end for the LPC encoder. Accepts a sample stream, buffers it in an internal FIFO and re-emits it as fixed-length analysis frames of FRAME_LEN samples, with a frame-end marker on each frame.
- TUSER acts as an in-band resync marker.
- Optional zero-padding completes short frames cut by TLAST.
- Sits between the external AXI-S source and the encoder core's sample input.

Parameters:
DATA_W, 16, sample width in bits
FRAME_LEN, 4, samples per frame (>=2)
FIFO_DEPTH, 8, buffer entries (power of 2, >=2)
PAD_SHORT, 1, 1 = zero-pad frames cut short by TLAST; 0 = emit short frame

Ports:
ACLK  in  1  clock
ARESET_N  in  1  async reset, active-low
TVALID  in  1  input beat valid
TREADY  out  1  input beat accept
TDATA  in  DATA_W  input sample
TLAST  in  1  end of input stream/packet
TUSER  in  1  resync marker; beat data discarded
READY  in  1  downstream accept
VALID  out  1  output beat valid
SAMPLE  out  DATA_W  output sample
LAST  out  1  last sample of frame
SAMPLE_LAST  out  1  this beat carried TLAST
USER_OUT  out  1  one-cycle pulse on resync
LEVEL  out  clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset is ARESET_N, asynchronous, active-low; clock is ACLK.
  - Reset values: VALID=0, SAMPLE=0, LAST=0, SAMPLE_LAST=0, USER_OUT=0, LEVEL=0, TREADY=0.
  - Internal rst_done flag resets to 0 and sets on the first ACLK edge after release.
- Input side:
  - TREADY = rst_done AND (LEVEL < FIFO_DEPTH), driven from registered state only.
  - Accept on TVALID&TREADY. Each accepted beat writes entry {TUSER, TLAST, TDATA}.
  - For a TUSER beat, TDATA and TLAST are ignored (stored as 0).
- FIFO:
  - Synchronous, registered count. Push and pop in the same cycle keep LEVEL unchanged.
  - No push when full, no pop when empty. Pointers wrap modulo FIFO_DEPTH.
- Output register:
  - VALID/SAMPLE/LAST/SAMPLE_LAST are registered.
  - While VALID & ~READY, all outputs hold stable.
  - Register loads when empty or on READY handshake.
  - Minimum latency: beat accepted at edge N shows VALID=1 after edge N+1.
  - Full throughput of 1 beat/cycle with READY held high.
- Frame counter fcnt (0..FRAME_LEN-1):
  - LAST = (beat is at fcnt==FRAME_LEN-1), or forced per the PAD rules below.
  - Advances on VALID&READY; wraps to 0 after the last beat of a frame.
- FSM states PASS, PAD:
  - PASS, data entry popped: emit it.
  - If the entry has TLAST and fcnt != FRAME_LEN-1:
    - PAD_SHORT=1: emit with LAST=0, SAMPLE_LAST=1, then go to PAD.
    - PAD_SHORT=0: emit with LAST=1, SAMPLE_LAST=1; fcnt reset to 0.
  - TLAST at fcnt==FRAME_LEN-1: LAST=1, SAMPLE_LAST=1, stay in PASS.
  - PAD: emit SAMPLE=0, SAMPLE_LAST=0 beats until the frame completes. The final pad beat has LAST=1, then return to PASS. No FIFO pops in PAD.
  - PASS, TUSER entry popped: no output beat; fcnt=0; USER_OUT=1 for exactly one cycle.
  - A TUSER entry is popped only when the output register is empty or being handshaken.
  - Consecutive markers give one pulse per marker on consecutive cycles.
- Reset mid-frame: all state is cleared immediately, FIFO contents are discarded, and the next frame starts at fcnt=0.

Decomposition:
- Shared package lpc_enc_pkg holds:
  - FIFO entry field offsets (USER_BIT, LAST_BIT).
  - FSM state enum {PASS, PAD}.
  - Default DATA_W and FRAME_LEN constants.
- Sub-module axis_sync_fifo (WIDTH=DATA_W+2, DEPTH=FIFO_DEPTH) provides push/pop/full/empty/level. The FSM and output register live in the top.

Test Plan:
- Streaming, READY=1: 8 beats 0x0001..0x0008, no TLAST -> 8 outputs in order, LAST=1 on 0x0004 and 0x0008, first VALID two edges after first accept.
- Backpressure: READY=0 with 10 beats offered -> TREADY drops after 8 accepts with LEVEL=8 (plus the held output beat); outputs stable; release READY -> all 10 delivered in order, none lost.
- Short frame, PAD_SHORT=1: beats 0xA,0xB with TLAST on 0xB -> outputs 0xA, 0xB(SAMPLE_LAST=1, LAST=0), 0x0, 0x0(LAST=1).
- Short frame, PAD_SHORT=0: same stimulus -> outputs 0xA, 0xB(LAST=1, SAMPLE_LAST=1); next frame restarts at fcnt=0.
- Resync: 0x1,0x2, TUSER beat(0xFFFF), 0x3..0x6 -> 0xFFFF never output, USER_OUT single pulse, LAST on 0x6 not 0x4.
- Reset mid-frame: assert ARESET_N=0 after 2 of 4 beats with FIFO non-empty -> all outputs 0 immediately; after release, new 4-beat frame has LAST on its 4th beat.
